// File: rtl/serv_csr_irq.sv
// -----------------------------------------------------------------------------
// serv_csr_irq
//
// Bit-serial machine-mode CSR unit with NUM_IRQ level-sensitive interrupt
// lines. Sits beside the register file and serial ALU and is stepped one bit
// per cycle (LSB first) by the core's state counter.
//
// Implemented CSR state:
//   mstatus : MIE (bit 3), MPIE (bit 7)
//   mie     : bits [NUM_IRQ-1:0], fully writable
//   mip     : bits [NUM_IRQ-1:0], read-only view of the sampled irq lines
//   mcause  : exception code [CAUSE_W-1:0] and interrupt flag (bit 31)
// All other bits read as 0 and ignore writes.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_en, i_cnt           serial step valid, current bit index 0..31
//   i_irq                 level interrupt requests, synchronous to i_clk
//   i_trap_taken, i_mret  single-cycle trap entry / mret pulses
//   i_e_op, i_ebreak      ecall/ebreak qualifiers for the trap cause
//   i_mem_misalign,
//   i_mem_cmd             misaligned access qualifiers (cmd=1 -> store)
//   i_*_en                one-hot CSR select (or all 0)
//   i_csr_source          00 CSR, 01 EXT, 10 SET, 11 CLR
//   i_csr_d_sel           1: serial data from i_csr_imm, 0: from i_rs1
//   i_rf_csr_out          serial CSR bit coming back from the register file
//   o_csr_in              serial write-back bit
//   o_q                   serial CSR read bit
//   o_irq_pending         registered: an enabled interrupt is pending
//   o_new_irq             rising edge of the enabled-pending condition
// -----------------------------------------------------------------------------
module serv_csr_irq #(
  parameter int NUM_IRQ = 3,
  parameter int CAUSE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [4:0]         i_cnt,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_trap_taken,
  input  logic               i_mret,
  input  logic               i_e_op,
  input  logic               i_ebreak,
  input  logic               i_mem_misalign,
  input  logic               i_mem_cmd,
  input  logic               i_mstatus_en,
  input  logic               i_mie_en,
  input  logic               i_mip_en,
  input  logic               i_mcause_en,
  input  logic [1:0]         i_csr_source,
  input  logic               i_csr_d_sel,
  input  logic               i_rf_csr_out,
  input  logic               i_csr_imm,
  input  logic               i_rs1,
  output logic               o_csr_in,
  output logic               o_q,
  output logic               o_irq_pending,
  output logic               o_new_irq
);

  localparam logic [1:0] SRC_CSR = 2'b00;
  localparam logic [1:0] SRC_EXT = 2'b01;
  localparam logic [1:0] SRC_SET = 2'b10;
  localparam logic [1:0] SRC_CLR = 2'b11;

  localparam logic [4:0] CNT_MIE   = 5'd3;
  localparam logic [4:0] CNT_MPIE  = 5'd7;
  localparam logic [4:0] CNT_MSB   = 5'd31;
  localparam logic [4:0] CNT_CAUSE = 5'(CAUSE_W);

  // Architectural state
  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [NUM_IRQ-1:0] mie;
  logic [CAUSE_W-1:0] code_sr;
  logic               mcause31;

  // Interrupt sampling pipeline
  logic [NUM_IRQ-1:0] irq_r;
  logic               pend_r;
  logic [CAUSE_W-1:0] sel_r;

  // Combinational helpers
  logic               d;
  logic               csr_out;
  logic               csr_in;
  logic               rd_bus;
  logic [31:0]        mie_word;
  logic [31:0]        mip_word;
  logic [NUM_IRQ-1:0] masked;
  logic               any_irq;
  logic [CAUSE_W-1:0] sel;
  logic [CAUSE_W-1:0] exc_code;
  logic               code_step;

  assign d = i_csr_d_sel ? i_csr_imm : i_rs1;

  // Zero-extended views so the serial read can index by i_cnt directly;
  // bits at and above NUM_IRQ fall out as 0.
  assign mie_word = {{(32-NUM_IRQ){1'b0}}, mie};
  assign mip_word = {{(32-NUM_IRQ){1'b0}}, irq_r};

  // The mcause code field is a shift register that shifts on every selected
  // bit below CAUSE_W. A plain read (CSR source) feeds csr_out back in, so
  // the field rotates once and ends up unchanged.
  assign code_step = i_cnt < CNT_CAUSE;

  // Serial read mux
  always_comb begin
    rd_bus = 1'b0;
    if (i_mstatus_en) begin
      rd_bus = ((i_cnt == CNT_MIE) & mstatus_mie) |
               ((i_cnt == CNT_MPIE) & mstatus_mpie);
    end
    if (i_mie_en) begin
      rd_bus = rd_bus | mie_word[i_cnt];
    end
    if (i_mip_en) begin
      rd_bus = rd_bus | mip_word[i_cnt];
    end
    if (i_mcause_en) begin
      rd_bus = rd_bus | (code_step ? code_sr[0] :
                         ((i_cnt == CNT_MSB) & mcause31));
    end
    csr_out = i_rf_csr_out | (i_en & rd_bus);
  end

  // Write-back bit by source
  always_comb begin
    csr_in = csr_out;
    case (i_csr_source)
      SRC_EXT: csr_in = d;
      SRC_SET: csr_in = csr_out | d;
      SRC_CLR: csr_in = csr_out & ~d;
      SRC_CSR: csr_in = csr_out;
      default: csr_in = csr_out;
    endcase
  end

  assign o_csr_in = csr_in;
  assign o_q      = csr_out;

  // Interrupt qualification
  assign masked  = irq_r & mie;
  assign any_irq = (|masked) & mstatus_mie;

  // Highest pending line wins: the loop runs upward so later hits override.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (masked[k]) begin
        sel = CAUSE_W'(k);
      end
    end
  end

  // Synchronous exception cause, first match wins
  always_comb begin
    exc_code = '0;
    if (i_e_op) begin
      exc_code = CAUSE_W'({~i_ebreak, 3'b011});
    end else if (i_mem_misalign) begin
      exc_code = CAUSE_W'({2'b01, i_mem_cmd, 1'b0});
    end
  end

  assign o_irq_pending = pend_r;
  assign o_new_irq     = any_irq & ~pend_r;

  // Interrupt sampling registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_r  <= '0;
      pend_r <= 1'b0;
      sel_r  <= '0;
    end else begin
      irq_r  <= i_irq;
      pend_r <= any_irq;
      sel_r  <= sel;
    end
  end

  // mie: software-owned, never touched by trap or mret
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mie <= '0;
    end else if (i_mie_en & i_en) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (i_cnt == 5'(k)) begin
          mie[k] <= csr_in;
        end
      end
    end
  end

  // mstatus: trap > mret > serial write
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (i_trap_taken) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (i_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (i_mstatus_en & i_en) begin
      if (i_cnt == CNT_MIE) begin
        mstatus_mie <= csr_in;
      end
      if (i_cnt == CNT_MPIE) begin
        mstatus_mpie <= csr_in;
      end
    end
  end

  // mcause: a trap overrides any serial write bit in the same cycle.
  // A pending interrupt outranks a simultaneous synchronous exception.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_sr  <= '0;
      mcause31 <= 1'b0;
    end else if (i_trap_taken) begin
      mcause31 <= pend_r;
      code_sr  <= pend_r ? sel_r : exc_code;
    end else if (i_mcause_en & i_en) begin
      if (code_step) begin
        code_sr <= {csr_in, code_sr[CAUSE_W-1:1]};
      end
      if (i_cnt == CNT_MSB) begin
        mcause31 <= csr_in;
      end
    end
  end

endmodule

// File: tb/tb_serv_csr_irq.sv
// -----------------------------------------------------------------------------
// tb_serv_csr_irq
//
// Directed and randomized bench for serv_csr_irq (NUM_IRQ=3, CAUSE_W=4).
// A word-level model of the CSRs (mie/mstatus/mcause as plain integers and
// the interrupt lines as a vector) predicts each whole 32-bit serial read and
// write-back word, trap causes and the pending flag.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_serv_csr_irq;

  localparam int NUM_IRQ = 3;
  localparam int CAUSE_W = 4;

  localparam int MSTATUS = 0;
  localparam int MIE     = 1;
  localparam int MIP     = 2;
  localparam int MCAUSE  = 3;

  localparam logic [1:0] CSR = 2'b00;
  localparam logic [1:0] EXT = 2'b01;
  localparam logic [1:0] SET = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic               i_clk;
  logic               i_rst;
  logic               i_en;
  logic [4:0]         i_cnt;
  logic [NUM_IRQ-1:0] i_irq;
  logic               i_trap_taken;
  logic               i_mret;
  logic               i_e_op;
  logic               i_ebreak;
  logic               i_mem_misalign;
  logic               i_mem_cmd;
  logic               i_mstatus_en;
  logic               i_mie_en;
  logic               i_mip_en;
  logic               i_mcause_en;
  logic [1:0]         i_csr_source;
  logic               i_csr_d_sel;
  logic               i_rf_csr_out;
  logic               i_csr_imm;
  logic               i_rs1;
  logic               o_csr_in;
  logic               o_q;
  logic               o_irq_pending;
  logic               o_new_irq;

  int errors;
  int checks;

  // Reference model state
  logic [NUM_IRQ-1:0] m_mie;
  logic               m_sie;
  logic               m_mpie;
  logic [3:0]         m_code;
  logic               m_int;
  logic [NUM_IRQ-1:0] m_irq;

  serv_csr_irq #(
    .NUM_IRQ(NUM_IRQ),
    .CAUSE_W(CAUSE_W)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .i_cnt          (i_cnt),
    .i_irq          (i_irq),
    .i_trap_taken   (i_trap_taken),
    .i_mret         (i_mret),
    .i_e_op         (i_e_op),
    .i_ebreak       (i_ebreak),
    .i_mem_misalign (i_mem_misalign),
    .i_mem_cmd      (i_mem_cmd),
    .i_mstatus_en   (i_mstatus_en),
    .i_mie_en       (i_mie_en),
    .i_mip_en       (i_mip_en),
    .i_mcause_en    (i_mcause_en),
    .i_csr_source   (i_csr_source),
    .i_csr_d_sel    (i_csr_d_sel),
    .i_rf_csr_out   (i_rf_csr_out),
    .i_csr_imm      (i_csr_imm),
    .i_rs1          (i_rs1),
    .o_csr_in       (o_csr_in),
    .o_q            (o_q),
    .o_irq_pending  (o_irq_pending),
    .o_new_irq      (o_new_irq)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] model_read(input int which);
    logic [31:0] v;
    v = 32'd0;
    case (which)
      MSTATUS: v = (32'(m_mpie) << 7) | (32'(m_sie) << 3);
      MIE:     v = 32'(m_mie);
      MIP:     v = 32'(m_irq);
      default: v = (32'(m_int) << 31) | 32'(m_code);
    endcase
    return v;
  endfunction

  function automatic logic model_pending();
    return ((m_irq & m_mie) != '0) && m_sie;
  endfunction

  function automatic logic [3:0] model_sel();
    logic [3:0] s;
    s = 4'd0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (m_irq[k] && m_mie[k]) s = 4'(k);
    end
    return s;
  endfunction

  task automatic model_reset();
    m_mie  = '0;
    m_sie  = 1'b0;
    m_mpie = 1'b0;
    m_code = 4'd0;
    m_int  = 1'b0;
  endtask

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    i_en           = 1'b0;
    i_cnt          = 5'd0;
    i_trap_taken   = 1'b0;
    i_mret         = 1'b0;
    i_e_op         = 1'b0;
    i_ebreak       = 1'b0;
    i_mem_misalign = 1'b0;
    i_mem_cmd      = 1'b0;
    i_mstatus_en   = 1'b0;
    i_mie_en       = 1'b0;
    i_mip_en       = 1'b0;
    i_mcause_en    = 1'b0;
    i_csr_source   = CSR;
    i_csr_d_sel    = 1'b0;
    i_rf_csr_out   = 1'b0;
    i_csr_imm      = 1'b0;
    i_rs1          = 1'b0;
  endtask

  // Full 32-bit serial CSR access; checks the read word and the write-back
  // word against the model, then updates the model. Returns the read word
  // and how many sampled cycles showed o_new_irq high.
  task automatic csr_access(input int which, input logic [1:0] src,
                            input logic [31:0] d, input logic use_imm,
                            output logic [31:0] q, output int pulses);
    logic [31:0] exp_q;
    logic [31:0] exp_in;
    logic [31:0] in_w;
    exp_q = model_read(which);
    case (src)
      EXT:     exp_in = d;
      SET:     exp_in = exp_q | d;
      CLR:     exp_in = exp_q & ~d;
      default: exp_in = exp_q;
    endcase
    pulses = 0;
    q      = 32'd0;
    in_w   = 32'd0;
    for (int i = 0; i < 32; i++) begin
      @(posedge i_clk);
      #1;
      i_en         = 1'b1;
      i_cnt        = 5'(i);
      i_mstatus_en = (which == MSTATUS);
      i_mie_en     = (which == MIE);
      i_mip_en     = (which == MIP);
      i_mcause_en  = (which == MCAUSE);
      i_csr_source = src;
      i_csr_d_sel  = use_imm;
      i_csr_imm    = use_imm ? d[i] : 1'($urandom);
      i_rs1        = use_imm ? 1'($urandom) : d[i];
      @(negedge i_clk);
      q[i]    = o_q;
      in_w[i] = o_csr_in;
      if (o_new_irq) pulses++;
    end
    @(posedge i_clk);
    #1;
    clear_inputs();
    check($sformatf("csr%0d_src%0d_read", which, src), q, exp_q);
    check($sformatf("csr%0d_src%0d_csr_in", which, src), in_w, exp_in);
    case (which)
      MSTATUS: begin
        m_sie  = exp_in[3];
        m_mpie = exp_in[7];
      end
      MIE:    m_mie = exp_in[NUM_IRQ-1:0];
      MCAUSE: begin
        m_code = exp_in[3:0];
        m_int  = exp_in[31];
      end
      default: ;
    endcase
  endtask

  task automatic do_trap(input logic e_op, input logic ebreak,
                         input logic mis, input logic cmd);
    @(posedge i_clk);
    #1;
    i_trap_taken   = 1'b1;
    i_e_op         = e_op;
    i_ebreak       = ebreak;
    i_mem_misalign = mis;
    i_mem_cmd      = cmd;
    if (model_pending()) begin
      m_int  = 1'b1;
      m_code = model_sel();
    end else begin
      m_int = 1'b0;
      if (e_op)     m_code = ebreak ? 4'd3 : 4'd11;
      else if (mis) m_code = cmd ? 4'd6 : 4'd4;
      else          m_code = 4'd0;
    end
    m_mpie = m_sie;
    m_sie  = 1'b0;
    @(posedge i_clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_mret();
    @(posedge i_clk);
    #1;
    i_mret = 1'b1;
    m_sie  = m_mpie;
    m_mpie = 1'b1;
    @(posedge i_clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_irq(input logic [NUM_IRQ-1:0] v);
    @(posedge i_clk);
    #1;
    i_irq = v;
    m_irq = v;
  endtask

  task automatic check_settled(input string tag);
    @(negedge i_clk);
    check({tag, "_pending"}, 32'(o_irq_pending), 32'(model_pending()));
    check({tag, "_new_irq"}, 32'(o_new_irq), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] q;
    int          pulses;
    int          act;
    errors = 0;
    checks = 0;
    clear_inputs();
    i_irq = '0;
    m_irq = '0;
    model_reset();
    i_rst = 1'b1;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_pending", 32'(o_irq_pending), 32'd0);
    check("rst_new_irq", 32'(o_new_irq), 32'd0);
    check("rst_q", 32'(o_q), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(2);
    csr_access(MSTATUS, CSR, 32'd0, 1'b0, q, pulses);
    csr_access(MIE, CSR, 32'd0, 1'b0, q, pulses);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);

    // 1: EXT write mie=5, read back, mip with no irq
    csr_access(MIE, EXT, 32'h5, 1'b0, q, pulses);
    csr_access(MIE, CSR, 32'd0, 1'b0, q, pulses);
    check("t1_mie_read", q, 32'h0000_0005);
    csr_access(MIP, CSR, 32'd0, 1'b0, q, pulses);
    check("t1_mip_read", q, 32'h0);

    // 2: single interrupt, edge timing, trap cause
    csr_access(MIE, EXT, 32'h4, 1'b1, q, pulses);
    csr_access(MSTATUS, EXT, 32'h8, 1'b0, q, pulses);
    idle(2);
    set_irq(3'b100);
    @(negedge i_clk);
    check("t2_new_before", 32'(o_new_irq), 32'd0);
    check("t2_pend_before", 32'(o_irq_pending), 32'd0);
    @(negedge i_clk);
    check("t2_new_pulse", 32'(o_new_irq), 32'd1);
    check("t2_pend_early", 32'(o_irq_pending), 32'd0);
    @(negedge i_clk);
    check("t2_new_after", 32'(o_new_irq), 32'd0);
    check("t2_pend_set", 32'(o_irq_pending), 32'd1);
    idle(1);
    do_trap(1'b1, 1'b0, 1'b0, 1'b0);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t2_mcause", q, 32'h8000_0002);
    csr_access(MSTATUS, CSR, 32'd0, 1'b0, q, pulses);
    check("t2_mstatus", q, 32'h0000_0080);
    idle(2);
    check_settled("t2_post_trap");

    // 3: highest index wins, mret restores
    csr_access(MIE, EXT, 32'h7, 1'b0, q, pulses);
    set_irq(3'b011);
    csr_access(MSTATUS, EXT, 32'h8, 1'b0, q, pulses);
    idle(2);
    do_trap(1'b0, 1'b0, 1'b0, 1'b0);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t3_mcause", q, 32'h8000_0001);
    do_mret();
    csr_access(MSTATUS, CSR, 32'd0, 1'b0, q, pulses);
    check("t3_mstatus", q, 32'h0000_0088);

    // 4: exception causes with nothing pending
    set_irq(3'b000);
    idle(2);
    do_trap(1'b1, 1'b0, 1'b1, 1'b1);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t4_ecall", q, 32'd11);
    do_trap(1'b0, 1'b0, 1'b1, 1'b1);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t4_store_mis", q, 32'd6);
    do_trap(1'b0, 1'b0, 1'b0, 1'b0);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t4_jump_mis", q, 32'd0);

    // 5: global disable masks everything, SET mstatus.mie produces one edge
    csr_access(MSTATUS, EXT, 32'h0, 1'b0, q, pulses);
    set_irq(3'b111);
    csr_access(MIE, EXT, 32'h7, 1'b0, q, pulses);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("t5_new_masked", 32'(o_new_irq), 32'd0);
      check("t5_pend_masked", 32'(o_irq_pending), 32'd0);
    end
    csr_access(MSTATUS, SET, 32'h8, 1'b1, q, pulses);
    check("t5_edge_count", 32'(pulses), 32'd1);
    idle(1);
    check_settled("t5_enabled");

    // 6: reset in the middle of an mcause write
    @(negedge i_clk);
    check("t6_pend_before", 32'(o_irq_pending), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      i_en         = 1'b1;
      i_cnt        = 5'(i);
      i_mcause_en  = 1'b1;
      i_csr_source = EXT;
      i_rs1        = 1'b1;
    end
    #1;
    i_rst = 1'b1;
    #1;
    check("t6_pend_rst", 32'(o_irq_pending), 32'd0);
    check("t6_new_rst", 32'(o_new_irq), 32'd0);
    check("t6_q_rst", 32'(o_q), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    clear_inputs();
    i_rst = 1'b0;
    idle(2);
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    check("t6_mcause", q, 32'd0);
    csr_access(MIE, CSR, 32'd0, 1'b0, q, pulses);
    check("t6_mie", q, 32'd0);
    csr_access(MSTATUS, CSR, 32'd0, 1'b0, q, pulses);
    check("t6_mstatus", q, 32'd0);
    check_settled("t6_post");

    // Randomized mix against the model
    for (int n = 0; n < 80; n++) begin
      act = $urandom_range(0, 6);
      case (act)
        0, 1, 2: csr_access($urandom_range(0, 3), 2'($urandom_range(0, 3)),
                            $urandom, 1'($urandom), q, pulses);
        3:       do_trap(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        4:       do_mret();
        5:       set_irq(3'($urandom));
        default: csr_access(MSTATUS, 2'($urandom_range(1, 3)),
                            32'h88, 1'($urandom), q, pulses);
      endcase
      idle(2);
      check_settled($sformatf("rand%0d", n));
    end
    csr_access(MCAUSE, CSR, 32'd0, 1'b0, q, pulses);
    csr_access(MIE, CSR, 32'd0, 1'b0, q, pulses);
    csr_access(MSTATUS, CSR, 32'd0, 1'b0, q, pulses);
    csr_access(MIP, CSR, 32'd0, 1'b0, q, pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_csr_irq.md
Name: serv_csr_irq

Overview:
Parametrised bit-serial machine-mode CSR unit. It is the successor to the single-timer-interrupt CSR block in the SERV core. It supports NUM_IRQ level-sensitive interrupt lines, a fully software-writable mie, a readable mip and a readable/writable mstatus.MPIE. It sits beside the register file and the serial ALU, and is stepped one bit per cycle by the core's state counter.

Parameters:
NUM_IRQ, 3, number of interrupt lines, 1..16. Line k has cause code k and occupies mie/mip bit k.
CAUSE_W, 4, width of the mcause exception-code field, 4..5. Requires NUM_IRQ <= 2**CAUSE_W.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  serial bit step valid this cycle
i_cnt  in  5  current bit index 0..31 (LSB first)
i_irq  in  NUM_IRQ  interrupt request lines, level, synchronous to i_clk
i_trap_taken  in  1  one-cycle pulse: core enters trap
i_mret  in  1  one-cycle pulse: mret executed
i_e_op, i_ebreak  in  1  ecall/ebreak exception qualifiers
i_mem_misalign, i_mem_cmd  in  1  misaligned access; i_mem_cmd=1 means store
i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en  in  1  CSR select, one-hot or all 0
i_csr_source  in  2  00 CSR, 01 EXT (write), 10 SET, 11 CLR
i_csr_d_sel  in  1  1 selects i_csr_imm, 0 selects i_rs1
i_rf_csr_out, i_csr_imm, i_rs1  in  1  serial data bits
o_csr_in  out  1  serial write-back bit
o_q  out  1  serial CSR read bit
o_irq_pending  out  1  registered: an enabled interrupt is pending
o_new_irq  out  1  rising edge of the enabled-pending condition

Behaviour:
- Reset values: mstatus_mie=0, mstatus_mpie=0, mie=0, mcause=0, irq_r=0, pend_r=0. Therefore o_irq_pending=0 and o_new_irq=0 in reset.
- d = i_csr_d_sel ? i_csr_imm : i_rs1.
- csr_in by source: EXT=d, SET=csr_out|d, CLR=csr_out&~d, CSR=csr_out.
- csr_out is the OR of the following terms (all gated by i_en except i_rf_csr_out):
  - i_rf_csr_out;
  - mstatus_en & (cnt==3 ? mie : cnt==7 ? mpie : 0);
  - mie_en & mie[cnt], for cnt < NUM_IRQ;
  - mip_en & irq_r[cnt], for cnt < NUM_IRQ;
  - mcause_en & (cnt < CAUSE_W ? code_sr[0] : cnt==31 ? mcause31 : 0).
- Unimplemented bits read 0 and ignore writes. mip is read-only.
- Interrupt sampling:
  - irq_r <= i_irq every cycle.
  - masked = irq_r & mie. any = |masked & mstatus_mie.
  - pend_r <= any. o_irq_pending = pend_r. o_new_irq = any & !pend_r (combinational).
  - sel = highest index k with masked[k]=1, registered as sel_r each cycle.
- mie write: when i_mie_en & i_en & cnt<NUM_IRQ, mie[cnt] <= csr_in.
- mstatus update, priority trap > mret > write:
  - Trap: mpie <= mie, mie <= 0.
  - mret: mie <= mpie, mpie <= 1.
  - Write at cnt 3: mie <= csr_in. Write at cnt 7: mpie <= csr_in.
- mcause:
  - During a CSR access, the low field is a CAUSE_W-bit right shift register. While i_mcause_en & i_en & cnt<CAUSE_W: code_sr <= {csr_in, code_sr[CAUSE_W-1:1]}. At cnt 31: mcause31 <= csr_in.
  - On i_trap_taken, if pend_r=1: code <= sel_r and mcause31 <= 1 (interrupt takes priority over simultaneous exceptions).
  - Otherwise mcause31 <= 0, and code is taken from the first matching case:
    - i_e_op: {!i_ebreak,3'b011}, giving 3 (ebreak) or 11 (ecall);
    - i_mem_misalign: {2'b01,i_mem_cmd,1'b0}, giving 4 (load) or 6 (store);
    - else 0 (misaligned jump).
  - Codes are zero-extended to CAUSE_W.
- A trap in the same cycle as a serial CSR write: the trap update wins and the write bit is dropped.
- Asserting i_rst mid-instruction clears state immediately. The serial sequence is not resumed.
- Latency:
  - i_irq to o_irq_pending: 2 cycles.
  - i_irq to o_new_irq: 1 cycle.
  - Written mie/mstatus bits are visible in masking the cycle after the write bit.

Test Plan:
1. Reset, then EXT write 0x5 to mie (NUM_IRQ=3) -> subsequent CSR-source read of mie returns 0x00000005; mip read with i_irq=0 returns 0.
2. mie=0x4, mstatus.mie=1, raise i_irq[2] -> o_new_irq high for exactly 1 cycle after sampling, o_irq_pending=1 on the next cycle; i_trap_taken -> mcause reads 0x80000002, mstatus reads 0x80.
3. mie=0x7, i_irq=3'b011 -> trap gives mcause 0x80000001 (highest index wins); mret -> mstatus reads 0x88.
4. With no interrupt pending, trap with (i_e_op=1,i_ebreak=0) -> mcause 11; (i_mem_misalign=1,i_mem_cmd=1) -> 6; with nothing asserted -> 0.
5. mstatus.mie=0, i_irq=all 1s, mie=0x7 -> o_new_irq and o_irq_pending stay 0. SET 0x8 on mstatus -> o_new_irq pulses.
6. Assert i_rst during an mcause write at cnt=2 -> mcause=0, mie=0, all outputs 0 within the same cycle.
